// File: rtl/mac_verifier.sv
// mac_verifier: receives a frame of N data words followed by N tag words
// (N = BLOCK_W/WORD_W, LSB word first). It recomputes the expected MAC as
// data XOR key and reports a pass/fail verdict per frame over a valid/ready
// result port. It also keeps saturating pass/fail counters for the link
// status register.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   key[BLOCK_W]          MAC key, sampled when data word 0 is accepted
//   in_valid/in_ready     word handshake; in_word is the payload,
//                         in_last marks the final tag word
//   out_valid/out_ready   verdict handshake; auth_ok is the verdict
//   frame_err             one-cycle pulse when a malformed frame is dropped
//   pass_count/fail_count saturating verdict counters
//
// state     | meaning
// ----------+------------------------------------------------------------
// LOAD_DATA | accepting data words 0..N-1 (key latched with word 0)
// LOAD_TAG  | accepting tag words 0..N-1; last one must carry in_last
// COMPARE   | one cycle: register verdict, bump a counter
// REPORT    | verdict presented until out_ready, no words accepted
module mac_verifier #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 256,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               auth_ok,
  output logic               frame_err,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count
);

  localparam int N     = BLOCK_W / WORD_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    LOAD_DATA = 2'd0,
    LOAD_TAG  = 2'd1,
    COMPARE   = 2'd2,
    REPORT    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               ready_q, ready_nxt;
  logic               err_nxt;
  logic               xfer;
  logic               store_data, store_tag, latch_key, clear_frame, do_compare;
  logic [BLOCK_W-1:0] data_q, tag_q, key_q;
  logic               match;

  // in_ready is registered so it stays low through reset and the first
  // cycle after it; it tracks whether the next state accepts words.
  assign in_ready  = ready_q;
  assign xfer      = in_valid & ready_q;
  assign out_valid = (state == REPORT);
  assign match     = (tag_q == (data_q ^ key_q));

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    err_nxt     = 1'b0;
    store_data  = 1'b0;
    store_tag   = 1'b0;
    latch_key   = 1'b0;
    clear_frame = 1'b0;
    do_compare  = 1'b0;
    case (state)
      LOAD_DATA: begin
        if (xfer) begin
          if (in_last) begin
            err_nxt     = 1'b1;
            clear_frame = 1'b1;
            idx_nxt     = '0;
          end else begin
            store_data = 1'b1;
            latch_key  = (idx == '0);
            if (idx == LAST_IDX) begin
              idx_nxt   = '0;
              state_nxt = LOAD_TAG;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
      end
      LOAD_TAG: begin
        if (xfer) begin
          // in_last must be set on the final tag word and only there
          if (in_last != (idx == LAST_IDX)) begin
            err_nxt     = 1'b1;
            clear_frame = 1'b1;
            idx_nxt     = '0;
            state_nxt   = LOAD_DATA;
          end else begin
            store_tag = 1'b1;
            if (idx == LAST_IDX) begin
              idx_nxt   = '0;
              state_nxt = COMPARE;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
      end
      COMPARE: begin
        do_compare = 1'b1;
        state_nxt  = REPORT;
      end
      REPORT: begin
        if (out_ready) state_nxt = LOAD_DATA;
      end
      default: state_nxt = LOAD_DATA;
    endcase
    ready_nxt = (state_nxt == LOAD_DATA) || (state_nxt == LOAD_TAG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD_DATA;
      idx       <= '0;
      ready_q   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      ready_q   <= ready_nxt;
      frame_err <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      tag_q  <= '0;
      key_q  <= '0;
    end else if (clear_frame) begin
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      if (latch_key) key_q <= key;
      for (int k = 0; k < N; k++) begin
        if (store_data && (idx == IDX_W'(k))) data_q[WORD_W*k +: WORD_W] <= in_word;
        if (store_tag  && (idx == IDX_W'(k))) tag_q[WORD_W*k +: WORD_W]  <= in_word;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auth_ok    <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else if (do_compare) begin
      auth_ok <= match;
      if (match) begin
        if (!(&pass_count)) pass_count <= pass_count + 1'b1;
      end else begin
        if (!(&fail_count)) fail_count <= fail_count + 1'b1;
      end
    end
  end

endmodule
